sum_seg_display: RTL and testbench
==================================

# sum_seg_display

Output stage that consumes the ripple-carry adder's SUM and CO and drives the Nexys A7 8-digit common-anode seven-segment display. It latches a result on a load strobe, holds it, and time-multiplexes it across the digits with a programmable refresh divider. SUM is shown in hex on digits 3..0 and CO on digit 4. Digits 7..5 are always blank.

## Interface
- SIZE, 16: adder width; fixed at 16 (4 hex digits); other values are unsupported.
- REFRESH_DIV, 100_000: clk cycles per digit slot; 1 ms at 100 MHz. Must be ≥ 2.
- clk, input, 1: system clock. One clock domain.
- rst, input, 1: synchronous, active-high reset.
- ld, input, 1: load strobe; when high at an edge, SUM/CO are captured.
- SUM, input, SIZE: adder sum.
- CO, input, 1: adder carry-out.
- en, input, 1: display enable; low blanks all digits.
- an, output, 8: digit anodes, active-low; an[0] is the rightmost digit.
- seg, output, 7: segments, active-low; seg[0]=CA(a) … seg[6]=CG(g).
- dp, output, 1: decimal point, active-low; always 1.

## Operation
- Capture register val[16:0] = {CO,SUM}.
  - Loaded on any edge with ld=1; otherwise it holds.
  - Reset value is 0.
  - A held ld reloads every cycle.
- Refresh counter cnt.
  - Counts 0..REFRESH_DIV-1, then wraps to 0.
  - The wrap cycle is the tick.
  - On tick, digit index idx (3 bits) increments and wraps 7→0.
- Digit content by idx:
  - 0..3: hex of val[4*idx+3:4*idx].
  - 4: hex of val[16], i.e. '0' or '1'.
  - 5..7: blank (seg=7'h7F).
- Hex encoding, active-low:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Anode drive: an is all ones except bit idx, which is 0.
- en=0: an=8'hFF and seg=7'h7F. cnt, idx and val keep running and updating.
- Reset, including mid-scan: next edge gives cnt=0, idx=0, val=0, an=8'hFF, seg=7'h7F, dp=1. rst has priority over ld.

## Timing
- an and seg are registered from the current idx, val and en, giving 1-cycle latency.
- After reset deassert: the first edge drives an=8'hFE with seg showing '0'.
- Digit dwell is exactly REFRESH_DIV cycles. Full frame is 8·REFRESH_DIV cycles.
- Load with ld at edge N:
  - val is updated after N.
  - seg reflects the new value at edge N+1 if that digit is active.
- ld coincident with a tick: the next digit is displayed from the new val.
- en change takes effect on the next edge. No partial-digit glitch beyond that one cycle.

## Configuration
- LEADING_ZERO_BLANK_EN defined:
  - SUM digits above the most-significant nonzero nibble are blanked. Digit 0 is always shown, so SUM=0 shows a single '0'.
  - Digit 4 is shown as '1' when CO=1 and blanked when CO=0.
- Undefined: all four SUM digits are shown including leading zeros, and digit 4 always shows '0' or '1'.
- Blanking uses val, not live SUM.

## Structure
- Package seg_pkg holds:
  - the 16 hex segment constants;
  - SEG_BLANK=7'h7F;
  - NUM_DIGITS=8;
  - SUM_DIGITS=4;
  - CO_DIGIT=4.
- Sub-module hex_to_seg: combinational 4-bit → 7-bit active-low decoder, instantiated once on the muxed nibble.
- Top module sum_seg_display contains the capture register, refresh counter, idx, blanking logic and output registers.

## Test plan
Simulate with REFRESH_DIV=4.
- Reset: rst=1 for 3 cycles, then 0. Outputs are an=FF, seg=7F, dp=1 during reset. The first post-reset edge gives an=FE, seg=1000000.
- Load and scan: SUM=16'h1A2F, CO=1, ld pulse.
  - Over one frame, seg per digit 0..7 is: F=0001110, 2=0100100, A=0001000, 1=1111001, 1=1111001, then blank×3.
  - Each an pattern holds exactly 4 cycles.
- Hold: after the 16'h1A2F load, drive SUM=16'hFFFF with ld=0. The display is unchanged.
- Enable: set en=0 mid-frame. The next edge gives an=FF and seg=7F. Setting en=1 resumes at the idx the scan has advanced to, confirming the scan continued.
- Reset mid-scan: assert rst at idx=5 with ld=1 simultaneously. val becomes 0 and idx becomes 0.
- LEADING_ZERO_BLANK_EN: SUM=16'h0030, CO=0.
  - Digits 0 and 1 show '0' and '3'.
  - Digits 2, 3 and 4 are blank.
  - Without the macro: digits 2 and 3 show '0' and digit 4 shows '0'.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants for the sum/carry seven-segment output stage.
// Holds the active-low segment patterns for hex digits 0..F, the blank
// pattern, and the digit layout of the 8-digit display.
package seg_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int SUM_DIGITS = 4;
  localparam int CO_DIGIT   = 4;

  // Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment.
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;

endpackage

// File: rtl/sum_seg_display_hex_to_seg.sv
// hex_to_seg: combinational 4-bit to 7-segment decoder, active-low.
// Ports:
//   nib  in  4  hex nibble
//   seg  out 7  segments, seg[0]=a .. seg[6]=g, 0 = lit
module hex_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (nib)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/sum_seg_display.sv
// sum_seg_display: latches {CO,SUM} from the adder on ld and scans it across
// an 8-digit common-anode display. SUM in hex on digits 3..0, CO on digit 4,
// digits 7..5 blank. One digit slot lasts REFRESH_DIV clocks.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks SUM digits above the
// most-significant nonzero nibble (digit 0 always shown) and shows the CO
// digit only when CO=1.
// Ports:
//   clk  in   1     system clock
//   rst  in   1     synchronous active-high reset
//   ld   in   1     capture strobe for SUM/CO
//   SUM  in   SIZE  adder sum (SIZE must be 16)
//   CO   in   1     adder carry-out
//   en   in   1     display enable, 0 blanks everything
//   an   out  8     digit anodes, active-low, an[0] rightmost
//   seg  out  7     segments, active-low
//   dp   out  1     decimal point, active-low, held off
module sum_seg_display
  import seg_pkg::*;
#(
  parameter int SIZE        = 16,
  parameter int REFRESH_DIV = 100_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ld,
  input  logic [SIZE-1:0]       SUM,
  input  logic                  CO,
  input  logic                  en,
  output logic [NUM_DIGITS-1:0] an,
  output logic [6:0]            seg,
  output logic                  dp
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  logic [SIZE:0]           val;
  logic [CW-1:0]           cnt;
  logic [2:0]              idx;
  logic                    tick;
  logic [3:0]              nib;
  logic                    show;
  logic [6:0]              dec;
  logic [NUM_DIGITS-1:0]   an_d;
  logic [6:0]              seg_d;

  assign tick = (cnt == CW'(REFRESH_DIV - 1));
  assign dp   = 1'b1;

  always_comb begin
    nib  = 4'h0;
    show = 1'b0;
    case (idx)
      3'd0: begin nib = val[3:0];   show = 1'b1; end
`ifdef LEADING_ZERO_BLANK_EN
      // A digit is shown when it or any nibble above it is nonzero.
      3'd1: begin nib = val[7:4];   show = |val[15:4];  end
      3'd2: begin nib = val[11:8];  show = |val[15:8];  end
      3'd3: begin nib = val[15:12]; show = |val[15:12]; end
      3'd4: begin nib = {3'b000, val[16]}; show = val[16]; end
`else
      3'd1: begin nib = val[7:4];   show = 1'b1; end
      3'd2: begin nib = val[11:8];  show = 1'b1; end
      3'd3: begin nib = val[15:12]; show = 1'b1; end
      3'd4: begin nib = {3'b000, val[16]}; show = 1'b1; end
`endif
      default: begin nib = 4'h0; show = 1'b0; end
    endcase
  end

  hex_to_seg u_dec (
    .nib (nib),
    .seg (dec)
  );

  always_comb begin
    an_d  = 8'hFF;
    seg_d = SEG_BLANK;
    if (en) begin
      an_d = ~(8'h01 << idx);
      if (show) seg_d = dec;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      val <= '0;
      cnt <= '0;
      idx <= 3'd0;
      an  <= 8'hFF;
      seg <= SEG_BLANK;
    end else begin
      if (ld) val <= {CO, SUM};
      if (tick) begin
        cnt <= '0;
        idx <= idx + 3'd1;
      end else begin
        cnt <= cnt + CW'(1);
      end
      an  <= an_d;
      seg <= seg_d;
    end
  end

endmodule

// File: tb/tb_sum_seg_display.sv
module tb_sum_seg_display;

  localparam int RD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ld  = 1'b0;
  logic [15:0] SUM = 16'h0;
  logic        CO  = 1'b0;
  logic        en  = 1'b1;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;

  sum_seg_display #(.SIZE(16), .REFRESH_DIV(RD)) dut (
    .clk(clk), .rst(rst), .ld(ld), .SUM(SUM), .CO(CO), .en(en),
    .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] an;
    logic [6:0] seg;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [16:0] m_val = '0;
  int          m_cnt = 0;
  int          m_idx = 0;

  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  function automatic logic [6:0] model_seg(input int d, input logic [16:0] v, input logic e);
    logic [15:0] s;
    logic        vis;
    if (!e) return 7'h7F;
    s = v[15:0] >> (4 * d);
    if (d <= 3) begin
`ifdef LEADING_ZERO_BLANK_EN
      vis = (d == 0) || (s != 16'h0);
`else
      vis = 1'b1;
`endif
      return vis ? hex7(s[3:0]) : 7'h7F;
    end
    if (d == 4) begin
`ifdef LEADING_ZERO_BLANK_EN
      return v[16] ? hex7(4'h1) : 7'h7F;
`else
      return hex7({3'b000, v[16]});
`endif
    end
    return 7'h7F;
  endfunction

  // One clock: drive inputs, predict the post-edge outputs, compare after the edge.
  task automatic step(input logic r, input logic l, input logic [15:0] s,
                      input logic c, input logic e);
    exp_t x;
    rst = r; ld = l; SUM = s; CO = c; en = e;
    if (r) begin
      x.an = 8'hFF; x.seg = 7'h7F;
      m_val = '0; m_cnt = 0; m_idx = 0;
    end else begin
      x.an  = e ? ~(8'h01 << m_idx) : 8'hFF;
      x.seg = model_seg(m_idx, m_val, e);
      if (l) m_val = {c, s};
      if (m_cnt == RD - 1) begin
        m_cnt = 0;
        m_idx = (m_idx + 1) % 8;
      end else begin
        m_cnt = m_cnt + 1;
      end
    end
    sb.push_back(x);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    n_vec++;
    assert (an === x.an && seg === x.seg && dp === 1'b1) else begin
      n_err++;
      $error("FAIL scan: an=%h seg=%b dp=%b, expected an=%h seg=%b dp=1",
             an, seg, dp, x.an, x.seg);
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] ea, input logic [6:0] es);
    n_vec++;
    assert (an === ea && seg === es) else begin
      n_err++;
      $error("FAIL %s: an=%h seg=%b, expected an=%h seg=%b", tag, an, seg, ea, es);
    end
  endtask

  task automatic run_to(input int target, input logic l, input logic [15:0] s,
                        input logic c, input logic e);
    int n;
    n = 0;
    while (!(m_idx == target && m_cnt == 0) && n < 64) begin
      step(1'b0, l, s, c, e);
      n++;
    end
    if (n >= 64) begin
      n_vec++; n_err++;
      $error("FAIL run_to: idx=%0d not reached within 64 cycles", target);
    end
  endtask

  logic [6:0] frame1 [8];
  logic [6:0] frame2 [8];

  initial begin
    frame1 = '{7'b0001110, 7'b0100100, 7'b0001000, 7'b1111001,
               7'b1111001, 7'h7F, 7'h7F, 7'h7F};
`ifdef LEADING_ZERO_BLANK_EN
    frame2 = '{7'b1000000, 7'b0110000, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
`else
    frame2 = '{7'b1000000, 7'b0110000, 7'b1000000, 7'b1000000,
               7'b1000000, 7'h7F, 7'h7F, 7'h7F};
`endif

    // Reset held for 3 cycles.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
      chk("reset", 8'hFF, 7'h7F);
    end
    step(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
    chk("first_edge", 8'hFE, 7'b1000000);

    // Load 1A2F with carry, then scan one full frame while SUM changes (hold).
    step(1'b0, 1'b1, 16'h1A2F, 1'b1, 1'b1);
    run_to(0, 1'b0, 16'h1A2F, 1'b1, 1'b1);
    for (int d = 0; d < 8; d++)
      for (int k = 0; k < RD; k++) begin
        step(1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b1);
        chk($sformatf("frame_d%0d_c%0d", d, k), ~(8'h01 << d), frame1[d]);
      end

    // Disable mid-frame, let the scan advance, re-enable at digit 3.
    step(1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b1);
    step(1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0);
    chk("en_off", 8'hFF, 7'h7F);
    run_to(3, 1'b0, 16'hFFFF, 1'b0, 1'b0);
    step(1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b1);
    chk("en_resume", 8'hF7, 7'b1111001);

    // Reset at digit 5 with a coincident load: reset wins.
    run_to(5, 1'b0, 16'hFFFF, 1'b0, 1'b1);
    step(1'b1, 1'b1, 16'hBEEF, 1'b1, 1'b1);
    chk("midscan_rst", 8'hFF, 7'h7F);
    step(1'b0, 1'b0, 16'hBEEF, 1'b1, 1'b1);
    chk("after_rst", 8'hFE, 7'b1000000);

    // Leading-zero case: 0030 with CO=0.
    step(1'b0, 1'b1, 16'h0030, 1'b0, 1'b1);
    run_to(0, 1'b0, 16'h0030, 1'b0, 1'b1);
    for (int d = 0; d < 8; d++)
      for (int k = 0; k < RD; k++) begin
        step(1'b0, 1'b0, 16'h0030, 1'b0, 1'b1);
        chk($sformatf("lzb_d%0d_c%0d", d, k), ~(8'h01 << d), frame2[d]);
      end

    // Load coincident with a tick: next digit uses the new value.
    run_to(1, 1'b0, 16'h0030, 1'b0, 1'b1);
    for (int k = 0; k < RD - 1; k++) step(1'b0, 1'b0, 16'h0030, 1'b0, 1'b1);
    step(1'b0, 1'b1, 16'h0C00, 1'b1, 1'b1);
    step(1'b0, 1'b0, 16'h0C00, 1'b1, 1'b1);
    chk("ld_on_tick", 8'hFB, 7'b1000110);
    for (int k = 0; k < 24; k++)
      step(1'b0, ($urandom_range(0, 3) == 0), 16'($urandom), 1'($urandom), 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
